aline_scan_sequencer: RTL and testbench
=======================================

Name: aline_scan_sequencer

Overview:
- Sequences a full scan of A-lines through the 8-channel A-line transmit FSM.
- Holds a host-loaded per-A-line, per-channel delay table and presents each A-line's delays on the delay_ch buses.
- Pulses input_delay_data to launch the transmit FSM, waits for transmit_complete, then enforces a pulse repetition interval (PRI) before the next A-line.
- Sits between the host/config interface and the transmit FSM.

Parameters:
NUM_CHANNELS, 8, transmit channels (fixed to 8 by the delay bus packing)
COUNT_NUM_BITS, 16, width of one channel delay
NUM_ALINES, 64, delay table depth in A-lines
ALINE_BITS, 6, log2(NUM_ALINES)
PRI_BITS, 20, width of PRI and timeout counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tbl_we  in  1  delay table write strobe
tbl_aline  in  ALINE_BITS  table write A-line address
tbl_ch  in  3  table write channel
tbl_data  in  COUNT_NUM_BITS  delay value written
num_alines  in  ALINE_BITS+1  A-lines per scan (1..NUM_ALINES), latched at start
pri_cycles  in  PRI_BITS  clocks from arm to next arm, latched at start
tx_timeout_cycles  in  PRI_BITS  max clocks to wait for transmit_complete, latched at start
start_scan  in  1  begin scan (sampled in IDLE only)
abort  in  1  stop scan at next safe point
transmit_complete  in  1  from transmit FSM (level; stays high until next transmit)
delay_flat  out  NUM_CHANNELS*COUNT_NUM_BITS  ch0 in [15:0], ch7 in MSBs; feeds delay_ch0..7
input_delay_data  out  1  one-cycle launch pulse to transmit FSM
aline_index  out  ALINE_BITS  A-line currently active
scan_busy  out  1  high from start accept to DONE exit
aline_done  out  1  one-cycle pulse per A-line completed
scan_done  out  1  one-cycle pulse at scan end (normal, abort or timeout)
tx_timeout  out  1  sticky error; cleared by rst or next accepted start_scan

Behaviour:
- Reset: all outputs 0, delay_flat 0, state IDLE. Table contents are not reset. rst mid-scan returns to IDLE the next cycle, with no scan_done.
- Table: 8 banks of NUM_ALINES x COUNT_NUM_BITS, one bank per channel. Writes are accepted only in IDLE; tbl_we while scan_busy is ignored. Reads are synchronous, 1-cycle latency.
- States: IDLE, FETCH, ARM, WAIT_TX, PRI_WAIT, DONE.
- IDLE: start_scan=1 with num_alines in 1..NUM_ALINES:
  - latch the three config inputs; aline_index<=0; clear tx_timeout; scan_busy<=1; go to FETCH.
  - num_alines=0 or >NUM_ALINES: start is ignored.
- FETCH (1 cycle): read all banks at aline_index, then go to ARM.
- ARM (1 cycle): delay_flat<=read data; input_delay_data=1 in the cycle after delay_flat updates. Implement this as ARM then a registered pulse, so that delays are stable at least 1 cycle before and 2 cycles after the pulse. Clear PRI counter and timeout counter to 0; go to WAIT_TX.
- WAIT_TX:
  - PRI and timeout counters increment each cycle.
  - Detect the 0->1 edge of transmit_complete using the registered previous value. The edge is ignored for the first 2 cycles after ARM, because the FSM holds transmit_complete from the previous line.
  - Edge -> pulse aline_done, go to PRI_WAIT.
  - Timeout counter == tx_timeout_cycles-1 without an edge -> tx_timeout<=1, go to DONE.
- PRI_WAIT:
  - When PRI counter >= pri_cycles-1, including on entry: if abort is pending or aline_index==num_alines-1, go to DONE; else aline_index+1 and go to FETCH.
  - pri_cycles=0 or 1 behaves as "no extra wait".
- abort: latched when asserted in any busy state. It takes effect only at the PRI_WAIT exit; it never truncates an in-flight transmit.
- DONE (1 cycle): scan_done=1, scan_busy<=0, then IDLE.
- Counters saturate and never wrap.
- delay_flat holds the last A-line's values after the scan.

Test Plan:
- Load ch0..7 of A-line 0 with 10,20,..,80 and A-line 1 with 100..800. Set num_alines=2, pri=50, and a model FSM that raises transmit_complete 20 cycles after launch -> two input_delay_data pulses exactly 50 cycles apart, delay_flat correct at each pulse, two aline_done pulses, one scan_done, aline_index ends at 1.
- pri_cycles=5 with transmit taking 20 cycles -> next launch 1 cycle after PRI_WAIT entry plus FETCH/ARM (no extra wait).
- Model never completes, tx_timeout_cycles=100 -> tx_timeout=1 and scan_done at ~cycle 100 after launch; next start_scan clears tx_timeout.
- abort asserted mid-WAIT_TX of A-line 3 of 10 -> A-line 3 finishes (aline_done), no A-line 4 launch, scan_done, scan_busy=0.
- tbl_we during scan -> table unchanged (verify on the next scan). start_scan with num_alines=0 -> no activity.
- rst during PRI_WAIT -> IDLE next cycle, all outputs 0, no scan_done; a new scan then runs normally.

Source files
------------

// File: rtl/aline_scan_sequencer_if.sv
// Host/config, status and transmit-FSM signals of the A-line scan sequencer.
// master = host/transmit side, slave = sequencer.
interface aline_scan_sequencer_if #(
  parameter int NUM_CHANNELS   = 8,
  parameter int COUNT_NUM_BITS = 16,
  parameter int ALINE_BITS     = 6,
  parameter int PRI_BITS       = 20
);
  logic                                   tbl_we;
  logic [ALINE_BITS-1:0]                  tbl_aline;
  logic [2:0]                             tbl_ch;
  logic [COUNT_NUM_BITS-1:0]              tbl_data;
  logic [ALINE_BITS:0]                    num_alines;
  logic [PRI_BITS-1:0]                    pri_cycles;
  logic [PRI_BITS-1:0]                    tx_timeout_cycles;
  logic                                   start_scan;
  logic                                   abort;
  logic                                   transmit_complete;
  logic [NUM_CHANNELS*COUNT_NUM_BITS-1:0] delay_flat;
  logic                                   input_delay_data;
  logic [ALINE_BITS-1:0]                  aline_index;
  logic                                   scan_busy;
  logic                                   aline_done;
  logic                                   scan_done;
  logic                                   tx_timeout;

  modport master (
    output tbl_we, tbl_aline, tbl_ch, tbl_data, num_alines, pri_cycles,
           tx_timeout_cycles, start_scan, abort, transmit_complete,
    input  delay_flat, input_delay_data, aline_index, scan_busy,
           aline_done, scan_done, tx_timeout
  );

  modport slave (
    input  tbl_we, tbl_aline, tbl_ch, tbl_data, num_alines, pri_cycles,
           tx_timeout_cycles, start_scan, abort, transmit_complete,
    output delay_flat, input_delay_data, aline_index, scan_busy,
           aline_done, scan_done, tx_timeout
  );
endinterface

// File: rtl/aline_scan_sequencer.sv
// A-line scan sequencer: per-channel delay table, launch pulse to the transmit
// FSM, completion/timeout wait and pulse-repetition-interval pacing.

module aline_delay_bank #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Table contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

module aline_scan_sequencer #(
  parameter int NUM_CHANNELS   = 8,
  parameter int COUNT_NUM_BITS = 16,
  parameter int NUM_ALINES     = 64,
  parameter int ALINE_BITS     = 6,
  parameter int PRI_BITS       = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  aline_scan_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ARM      = 3'd2,
    S_WAIT_TX  = 3'd3,
    S_PRI_WAIT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ALINE_BITS:0]   L_MAX_AL = (ALINE_BITS+1)'(NUM_ALINES);
  localparam logic [ALINE_BITS:0]   L_ONE_N  = (ALINE_BITS+1)'(1);
  localparam logic [ALINE_BITS-1:0] L_ONE_A  = ALINE_BITS'(1);
  localparam logic [PRI_BITS-1:0]   L_ONE_P  = PRI_BITS'(1);
  localparam logic [PRI_BITS-1:0]   L_TWO_P  = PRI_BITS'(2);
  // FETCH, ARM and the launch register add 3 cycles between PRI_WAIT exit
  // and the next pulse; crediting them keeps pulse-to-pulse == pri_cycles.
  localparam logic [PRI_BITS+1:0]   L_LEAD   = (PRI_BITS+2)'(3);

  state_t                                  r_state;
  logic [ALINE_BITS:0]                     r_num;
  logic [PRI_BITS-1:0]                     r_pri;
  logic [PRI_BITS-1:0]                     r_tmo;
  logic [PRI_BITS-1:0]                     r_pri_cnt;
  logic [PRI_BITS-1:0]                     r_tmo_cnt;
  logic [ALINE_BITS-1:0]                   r_aline;
  logic                                    r_tc_prev;
  logic                                    r_abort;
  logic                                    r_arm_d;
  logic                                    r_idd;
  logic                                    r_busy;
  logic                                    r_aline_done;
  logic                                    r_scan_done;
  logic                                    r_tx_timeout;
  logic [NUM_CHANNELS*COUNT_NUM_BITS-1:0]  r_delay_flat;

  logic                                    w_start_ok;
  logic                                    w_tbl_wr;
  logic                                    w_tc_edge;
  logic                                    w_tmo_hit;
  logic                                    w_pri_met;
  logic                                    w_last;
  logic                                    w_stop;
  logic [PRI_BITS-1:0]                     w_pri_nxt;
  logic [PRI_BITS-1:0]                     w_tmo_nxt;
  logic [NUM_CHANNELS-1:0][COUNT_NUM_BITS-1:0] w_rd;

  assign w_start_ok = bus.start_scan && (bus.num_alines != '0) &&
                      (bus.num_alines <= L_MAX_AL);
  assign w_tbl_wr   = bus.tbl_we && (r_state == S_IDLE);
  // The transmit FSM still holds complete from the previous line for the
  // first two cycles after ARM, so edges there are not trusted.
  assign w_tc_edge  = bus.transmit_complete && !r_tc_prev && (r_tmo_cnt >= L_TWO_P);
  assign w_tmo_hit  = (r_tmo_cnt == r_tmo - L_ONE_P);
  assign w_pri_met  = ({2'b00, r_pri_cnt} + L_LEAD) >= {2'b00, r_pri};
  assign w_last     = ({1'b0, r_aline} == (r_num - L_ONE_N));
  assign w_stop     = r_abort || bus.abort || w_last;
  assign w_pri_nxt  = (&r_pri_cnt) ? r_pri_cnt : r_pri_cnt + L_ONE_P;
  assign w_tmo_nxt  = (&r_tmo_cnt) ? r_tmo_cnt : r_tmo_cnt + L_ONE_P;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_bank
    aline_delay_bank #(
      .DEPTH (NUM_ALINES),
      .AW    (ALINE_BITS),
      .DW    (COUNT_NUM_BITS)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_tbl_wr && (bus.tbl_ch == 3'(g))),
      .i_waddr (bus.tbl_aline),
      .i_wdata (bus.tbl_data),
      .i_re    (r_state == S_FETCH),
      .i_raddr (r_aline),
      .o_rdata (w_rd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_pri        <= '0;
      r_tmo        <= '0;
      r_pri_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_aline      <= '0;
      r_tc_prev    <= 1'b0;
      r_abort      <= 1'b0;
      r_arm_d      <= 1'b0;
      r_idd        <= 1'b0;
      r_busy       <= 1'b0;
      r_aline_done <= 1'b0;
      r_scan_done  <= 1'b0;
      r_tx_timeout <= 1'b0;
      r_delay_flat <= '0;
    end else begin
      r_tc_prev    <= bus.transmit_complete;
      r_arm_d      <= 1'b0;
      r_idd        <= r_arm_d;
      r_aline_done <= 1'b0;
      r_scan_done  <= 1'b0;
      if (r_busy && bus.abort) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_num        <= bus.num_alines;
            r_pri        <= bus.pri_cycles;
            r_tmo        <= bus.tx_timeout_cycles;
            r_aline      <= '0;
            r_tx_timeout <= 1'b0;
            r_abort      <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_ARM;
        S_ARM: begin
          r_delay_flat <= w_rd;
          r_arm_d      <= 1'b1;
          r_pri_cnt    <= '0;
          r_tmo_cnt    <= '0;
          r_state      <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          r_pri_cnt <= w_pri_nxt;
          r_tmo_cnt <= w_tmo_nxt;
          if (w_tc_edge) begin
            r_aline_done <= 1'b1;
            r_state      <= S_PRI_WAIT;
          end else if (w_tmo_hit) begin
            r_tx_timeout <= 1'b1;
            r_scan_done  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_PRI_WAIT: begin
          r_pri_cnt <= w_pri_nxt;
          if (w_pri_met) begin
            if (w_stop) begin
              r_scan_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_aline <= r_aline + L_ONE_A;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.delay_flat       = r_delay_flat;
  assign bus.input_delay_data = r_idd;
  assign bus.aline_index      = r_aline;
  assign bus.scan_busy        = r_busy;
  assign bus.aline_done       = r_aline_done;
  assign bus.scan_done        = r_scan_done;
  assign bus.tx_timeout       = r_tx_timeout;
endmodule

// File: tb/tb_aline_scan_sequencer.sv
// Scoreboard bench for aline_scan_sequencer: scan expectations are derived from
// the timing rules when a scan is issued; a negedge monitor pops and compares.
module tb_aline_scan_sequencer;
  typedef struct {
    int           cyc;
    logic [127:0] flat;
    int           idx;
    bit           tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q_pulse[$];
  exp_t q_adone[$];
  exp_t q_sdone[$];
  int   lat_q[$];
  logic [15:0] ref_tbl [64][8];

  aline_scan_sequencer_if bus ();

  aline_scan_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d: event not expected", nm, cyc);
  endtask

  function automatic logic [127:0] ref_flat(input int a);
    logic [127:0] f;
    for (int ch = 0; ch < 8; ch++) f[ch*16 +: 16] = ref_tbl[a][ch];
    return f;
  endfunction

  // Monitor: compares every DUT event against the head of its queue.
  initial begin : mon
    exp_t         me;
    logic [127:0] prev_flat;
    prev_flat = '0;
    forever begin
      @(negedge clk);
      if (bus.input_delay_data) begin
        if (q_pulse.size() == 0) fail_evt("pulse");
        else begin
          me = q_pulse.pop_front();
          chk("pulse_cyc", 128'(cyc), 128'(me.cyc));
          chk("pulse_flat", bus.delay_flat, me.flat);
          chk("flat_setup", prev_flat, me.flat);
          chk("pulse_idx", 128'(bus.aline_index), 128'(me.idx));
          chk("pulse_tmo_clear", 128'(bus.tx_timeout), 128'(0));
        end
      end
      if (bus.aline_done) begin
        if (q_adone.size() == 0) fail_evt("aline_done");
        else begin
          me = q_adone.pop_front();
          chk("adone_cyc", 128'(cyc), 128'(me.cyc));
          chk("adone_idx", 128'(bus.aline_index), 128'(me.idx));
        end
      end
      if (bus.scan_done) begin
        if (q_sdone.size() == 0) fail_evt("scan_done");
        else begin
          me = q_sdone.pop_front();
          chk("sdone_cyc", 128'(cyc), 128'(me.cyc));
          chk("sdone_tmo", 128'(bus.tx_timeout), 128'(me.tmo));
          chk("sdone_idx", 128'(bus.aline_index), 128'(me.idx));
          chk("sdone_busy", 128'(bus.scan_busy), 128'(1));
        end
      end
      prev_flat = bus.delay_flat;
    end
  end

  // Transmit FSM model: drops complete on launch, raises it after the latency
  // queued for that launch (0 = never completes).
  initial begin : txm
    int rise_at;
    int l;
    rise_at = -1;
    forever begin
      @(negedge clk);
      if (bus.input_delay_data) begin
        bus.transmit_complete = 1'b0;
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        rise_at = (l > 0) ? cyc + l : -1;
      end else if (rise_at >= 0 && cyc == rise_at) begin
        bus.transmit_complete = 1'b1;
        rise_at = -1;
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_flat"}, bus.delay_flat, '0);
    chk({tag, "_idd"}, 128'(bus.input_delay_data), 128'(0));
    chk({tag, "_idx"}, 128'(bus.aline_index), 128'(0));
    chk({tag, "_busy"}, 128'(bus.scan_busy), 128'(0));
    chk({tag, "_adone"}, 128'(bus.aline_done), 128'(0));
    chk({tag, "_sdone"}, 128'(bus.scan_done), 128'(0));
    chk({tag, "_tmo"}, 128'(bus.tx_timeout), 128'(0));
  endtask

  task automatic wr(input int a, input int ch, input logic [15:0] d);
    @(negedge clk);
    bus.tbl_we    = 1'b1;
    bus.tbl_aline = 6'(a);
    bus.tbl_ch    = 3'(ch);
    bus.tbl_data  = d;
    ref_tbl[a][ch] = d;
  endtask

  // lat_mode: >0 fixed latency, 0 never completes, <0 random latency.
  task automatic run_scan(input int n, input int p, input int t, input int lat_mode,
                          input int abort_line, input int rst_line, input bit wr_during);
    int   start_c, pulse, done, nxt, l, abort_at, rst_at;
    exp_t e;
    abort_at = -1;
    rst_at   = -1;
    @(negedge clk);
    start_c = cyc;
    // First launch: FETCH, ARM, delay setup cycle, then the pulse.
    pulse = start_c + 4;
    for (int k = 0; k < n; k++) begin
      l = (lat_mode < 0) ? int'($urandom_range(60, 3)) : lat_mode;
      lat_q.push_back(l);
      e.cyc = pulse; e.flat = ref_flat(k); e.idx = k; e.tmo = 1'b0;
      q_pulse.push_back(e);
      if (l == 0) begin
        e.cyc = pulse + t - 1; e.tmo = 1'b1;
        q_sdone.push_back(e);
        break;
      end
      done = pulse + l + 1;
      e.cyc = done;
      q_adone.push_back(e);
      if (k == abort_line) abort_at = pulse + 3;
      if (k == rst_line) begin
        rst_at = done + 2;
        break;
      end
      // Next launch is pri_cycles after this one, or 4 cycles after
      // aline_done when the PRI has already elapsed.
      nxt = (pulse + p > done + 4) ? pulse + p : done + 4;
      if (k == n - 1 || k == abort_line) begin
        e.cyc = nxt - 3;
        q_sdone.push_back(e);
        break;
      end
      pulse = nxt;
    end
    bus.num_alines        = 7'(n);
    bus.pri_cycles        = 20'(p);
    bus.tx_timeout_cycles = 20'(t);
    bus.start_scan        = 1'b1;
    forever begin
      @(negedge clk);
      bus.start_scan = 1'b0;
      bus.tbl_we     = 1'b0;
      bus.abort      = (cyc == abort_at);
      if (rst) begin
        rst = 1'b0;
        check_idle_zero("rst_mid");
      end else if (cyc == rst_at) rst = 1'b1;
      if (wr_during && cyc >= start_c + 10 && cyc < start_c + 14) begin
        bus.tbl_we    = 1'b1;
        bus.tbl_aline = 6'(cyc - start_c - 10);
        bus.tbl_ch    = 3'($urandom_range(7, 0));
        bus.tbl_data  = 16'($urandom);
      end
      if (!rst && !bus.scan_busy && cyc > start_c + 1) break;
      if (cyc > start_c + 20000) begin
        fail_evt("scan_end_bound");
        break;
      end
    end
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("queues_drained", 128'(q_pulse.size() + q_adone.size() + q_sdone.size()), 128'(0));
    q_pulse.delete(); q_adone.delete(); q_sdone.delete(); lat_q.delete();
  endtask

  task automatic start_ignored(input int n);
    @(negedge clk);
    bus.num_alines = 7'(n);
    bus.start_scan = 1'b1;
    @(negedge clk);
    bus.start_scan = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignored_busy", 128'(bus.scan_busy), 128'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.tbl_we = 1'b0; bus.tbl_aline = '0; bus.tbl_ch = '0; bus.tbl_data = '0;
    bus.num_alines = '0; bus.pri_cycles = '0; bus.tx_timeout_cycles = '0;
    bus.start_scan = 1'b0; bus.abort = 1'b0; bus.transmit_complete = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    for (int ch = 0; ch < 8; ch++) wr(0, ch, 16'((ch + 1) * 10));
    for (int ch = 0; ch < 8; ch++) wr(1, ch, 16'((ch + 1) * 100));
    for (int a = 2; a < 64; a++)
      for (int ch = 0; ch < 8; ch++) wr(a, ch, 16'($urandom));
    @(negedge clk);
    bus.tbl_we = 1'b0;

    run_scan(2, 50, 1000, 20, -1, -1, 1'b0);
    chk("end_idx", 128'(bus.aline_index), 128'(1));
    run_scan(3, 5, 1000, 20, -1, -1, 1'b0);
    run_scan(3, 40, 100, 0, -1, -1, 1'b0);
    chk("tx_timeout_sticky", 128'(bus.tx_timeout), 128'(1));
    run_scan(10, 30, 1000, -1, 3, -1, 1'b0);
    chk("abort_busy", 128'(bus.scan_busy), 128'(0));
    run_scan(4, 20, 1000, -1, -1, -1, 1'b1);
    run_scan(4, 0, 1000, -1, -1, -1, 1'b0);
    start_ignored(0);
    start_ignored(65);
    run_scan(3, 200, 1000, 10, -1, 0, 1'b0);
    run_scan(2, 50, 1000, 20, -1, -1, 1'b0);
    run_scan(64, 0, 1000, -1, -1, -1, 1'b0);
    for (int r = 0; r < 4; r++)
      run_scan(int'($urandom_range(12, 1)), int'($urandom_range(80, 0)), 1000, -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
